// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - nqcpu multi-cycle instruction sequencer
// Orders fetch, decode, data read, ALU, data write and writeback; owns the shared memory port.
module ctrl_sequencer #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic [ADDR_W-1:0] pc,
   input  logic [32:0]       ctrl_in,
   input  logic              flag_z,
   input  logic              flag_s,
   input  logic [ADDR_W-1:0] addr_reg_val,
   input  logic [DATA_W-1:0] alu_result,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   output logic              ir_load,
   output logic              mdr_load,
   output logic              pc_inc,
   output logic              alu_latch,
   output logic              reg_we_h,
   output logic              reg_we_l,
   output logic              pc_load,
   output logic [32:0]       ctrl_out,
   output logic              busy,
   output logic              trap
);

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, MEMRD, EXEC, MEMWR, WB, TRAP
   } state_t;

   state_t state, nextState;
   logic   condPass;

   // Fields of the incoming word, evaluated only while in DECODE
   logic       inRead, inWrite, inIllegal;
   logic [5:0] inCond;
   logic       zMatch, sMatch, condNow;

   assign inRead    = ctrl_in[9] | ctrl_in[8];
   assign inWrite   = ctrl_in[7] | ctrl_in[6];
   assign inIllegal = (inRead & inWrite) | (ctrl_in[9] & ctrl_in[8]) | (ctrl_in[7] & ctrl_in[6]);
   assign inCond    = ctrl_in[5:0];
   assign zMatch    = inCond[3] | (flag_z == inCond[1]);
   assign sMatch    = inCond[2] | (flag_s == inCond[0]);
   assign condNow   = ~inCond[5] | ((zMatch & sMatch) == inCond[4]);

   // Fields of the held word
   logic aluDest, regSetH, regSetL, memReadB, memWriteB, anyWrite;

   assign aluDest   = ctrl_out[18];
   assign regSetH   = ctrl_out[14];
   assign regSetL   = ctrl_out[13];
   assign memReadB  = ctrl_out[9];
   assign memWriteB = ctrl_out[7];
   assign anyWrite  = ctrl_out[7] | ctrl_out[6];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         ctrl_out <= '0;
         condPass <= 1'b0;
      end else begin
         state <= nextState;
         if (state == DECODE) begin
            ctrl_out <= ctrl_in;
            condPass <= condNow;
         end
      end
   end

   always_comb begin
      nextState = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_byte  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ir_load   = 1'b0;
      mdr_load  = 1'b0;
      pc_inc    = 1'b0;
      alu_latch = 1'b0;
      reg_we_h  = 1'b0;
      reg_we_l  = 1'b0;
      pc_load   = 1'b0;
      case (state)
         IDLE: if (run) nextState = FETCH;
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ack) begin
               ir_load   = 1'b1;
               pc_inc    = 1'b1;
               nextState = DECODE;
            end
         end
         DECODE: begin
            if (inIllegal)   nextState = TRAP;
            else if (inRead) nextState = MEMRD;
            else             nextState = EXEC;
         end
         MEMRD: begin
            mem_req  = 1'b1;
            mem_byte = memReadB;
            mem_addr = addr_reg_val;
            if (mem_ack) begin
               mdr_load  = 1'b1;
               nextState = EXEC;
            end
         end
         EXEC: begin
            alu_latch = 1'b1;
            nextState = anyWrite ? MEMWR : WB;
         end
         MEMWR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_byte  = memWriteB;
            mem_addr  = addr_reg_val;
            mem_wdata = alu_result;
            if (mem_ack) nextState = WB;
         end
         WB: begin
            // A PC-destined result never touches the register file
            reg_we_h  = condPass & regSetH & ~aluDest;
            reg_we_l  = condPass & regSetL & ~aluDest;
            pc_load   = condPass & aluDest;
            nextState = run ? FETCH : IDLE;
         end
         TRAP:    nextState = TRAP;
         default: nextState = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign trap = (state == TRAP);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - scoreboard bench for ctrl_sequencer
// Stimulus issues instructions and predicts the strobe/bus event stream; a monitor pops and compares.
module tb_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        reset_n, run;
   logic [15:0] pc, addr_reg_val, alu_result, mem_addr, mem_wdata;
   logic [32:0] ctrl_in, ctrl_out;
   logic        flag_z, flag_s, mem_ack;
   logic        mem_req, mem_we, mem_byte, ir_load, mdr_load, pc_inc, alu_latch;
   logic        reg_we_h, reg_we_l, pc_load, busy, trap;

   always #5 clk = ~clk;

   ctrl_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .pc(pc), .ctrl_in(ctrl_in),
      .flag_z(flag_z), .flag_s(flag_s), .addr_reg_val(addr_reg_val), .alu_result(alu_result),
      .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .ir_load(ir_load), .mdr_load(mdr_load),
      .pc_inc(pc_inc), .alu_latch(alu_latch), .reg_we_h(reg_we_h), .reg_we_l(reg_we_l),
      .pc_load(pc_load), .ctrl_out(ctrl_out), .busy(busy), .trap(trap)
   );

   typedef struct {
      logic [32:0] ctrl;
      logic        fz, fs;
      logic [15:0] areg, ares;
      int          wf, wd;
   } instr_t;

   // strb = {ir_load, mdr_load, pc_inc, alu_latch, reg_we_h, reg_we_l, pc_load}
   typedef struct {
      logic [6:0]  strb;
      logic        xfer, we, byt;
      logic [15:0] addr, wdata;
      logic [32:0] ctrl;
      int          gap;
   } ev_t;

   instr_t      instrQ[$];
   ev_t         expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          sinceLast = 0;
   bit          firstEv = 1'b1;
   logic [15:0] pcModel = 16'h0010;
   logic [32:0] lastCtrl;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic ev_t mkEv(input logic [6:0] s, input logic x, input logic we, input logic b,
                                input logic [15:0] a, input logic [15:0] d, input logic [32:0] c);
      ev_t e;
      e.strb = s; e.xfer = x; e.we = we; e.byt = b; e.addr = a; e.wdata = d; e.ctrl = c; e.gap = 0;
      return e;
   endfunction

   function automatic logic [32:0] mkCtrl(input logic aluDest, input logic h, input logic l,
                                          input logic [3:0] mem, input logic [5:0] cond);
      logic [32:0] c;
      c[31:0] = $urandom;
      c[32]   = 1'($urandom % 2);
      c[18] = aluDest; c[14] = h; c[13] = l; c[9:6] = mem; c[5:0] = cond;
      return c;
   endfunction

   function automatic bit condOk(input logic [5:0] c, input logic z, input logic s);
      bit zOk, sOk;
      if (!c[5]) return 1'b1;
      zOk = c[3] || (z == c[1]);
      sOk = c[2] || (s == c[0]);
      return (zOk && sOk) == c[4];
   endfunction

   // One reference cycle; an event records how many cycles passed since the previous one
   task automatic cyc(input bit isEv, input ev_t e);
      sinceLast++;
      if (isEv) begin
         e.gap = firstEv ? -1 : sinceLast;
         firstEv = 1'b0;
         sinceLast = 0;
         expQ.push_back(e);
      end
   endtask

   task automatic modelInstr(input instr_t in);
      logic [32:0] c;
      bit          rd, wr, pass;
      ev_t         nul;
      logic [6:0]  wbs;
      c = in.ctrl;
      rd = c[9] | c[8];
      wr = c[7] | c[6];
      nul = mkEv(7'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 33'h0);
      repeat (in.wf) cyc(1'b0, nul);
      cyc(1'b1, mkEv(7'b1010000, 1'b1, 1'b0, 1'b0, pcModel, 16'h0, c));
      pcModel = pcModel + 16'h1;
      cyc(1'b0, nul);
      if ((rd && wr) || (c[9] && c[8]) || (c[7] && c[6])) return;
      if (rd) begin
         repeat (in.wd) cyc(1'b0, nul);
         cyc(1'b1, mkEv(7'b0100000, 1'b1, 1'b0, c[9], in.areg, 16'h0, c));
      end
      cyc(1'b1, mkEv(7'b0001000, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, c));
      if (wr) begin
         repeat (in.wd) cyc(1'b0, nul);
         cyc(1'b1, mkEv(7'b0000000, 1'b1, 1'b1, c[7], in.areg, in.ares, c));
      end
      pass = condOk(c[5:0], in.fz, in.fs);
      wbs = {4'b0000, pass && c[14] && !c[18], pass && c[13] && !c[18], pass && c[18]};
      cyc(wbs != 7'd0, mkEv(wbs, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, c));
      if (wbs[0]) pcModel = in.ares;
   endtask

   task automatic issue(input instr_t i);
      instrQ.push_back(i);
      modelInstr(i);
      lastCtrl = i.ctrl;
   endtask

   function automatic instr_t mkInstr(input logic [32:0] c, input logic fz, input logic fs,
                                      input logic [15:0] areg, input logic [15:0] ares,
                                      input int wf, input int wd);
      instr_t i;
      i.ctrl = c; i.fz = fz; i.fs = fs; i.areg = areg; i.ares = ares; i.wf = wf; i.wd = wd;
      return i;
   endfunction

   function automatic instr_t randInstr();
      logic [3:0] m;
      case ($urandom % 5)
         0:       m = 4'b0000;
         1:       m = 4'b1000;
         2:       m = 4'b0100;
         3:       m = 4'b0010;
         default: m = 4'b0001;
      endcase
      return mkInstr(mkCtrl(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), m, 6'($urandom)),
                     1'($urandom % 2), 1'($urandom % 2), 16'($urandom), 16'($urandom),
                     int'($urandom % 4), int'($urandom % 4));
   endfunction

   // Datapath and memory environment: IR contents, PC register, ack generation with wait states
   initial begin
      instr_t cur;
      int     cnt, target;
      bit     capIr, capInc, capPl, capData, dataPending;
      pc = 16'h0010; ctrl_in = '0; flag_z = 1'b0; flag_s = 1'b0;
      addr_reg_val = '0; alu_result = '0; mem_ack = 1'b0;
      cnt = 0; dataPending = 1'b0;
      cur = mkInstr(33'h0, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0);
      forever begin
         @(negedge clk);
         capIr = ir_load; capInc = pc_inc; capPl = pc_load;
         capData = mem_req && mem_ack && !ir_load;
         @(posedge clk);
         #1;
         if (!reset_n) begin
            cnt = 0; dataPending = 1'b0; mem_ack = 1'($urandom % 2);
         end else begin
            if (capInc) pc = pc + 16'h1;
            if (capPl) pc = alu_result;
            if (capData) dataPending = 1'b0;
            if (capIr && instrQ.size() > 0) begin
               cur = instrQ.pop_front();
               ctrl_in = cur.ctrl; flag_z = cur.fz; flag_s = cur.fs;
               addr_reg_val = cur.areg; alu_result = cur.ares;
               dataPending = |cur.ctrl[9:6];
            end
            if (mem_req) begin
               target = dataPending ? cur.wd : (instrQ.size() > 0 ? instrQ[0].wf : 0);
               if (cnt >= target) begin mem_ack = 1'b1; cnt = 0; end
               else begin mem_ack = 1'b0; cnt++; end
            end else begin
               cnt = 0;
               mem_ack = 1'($urandom % 2);
            end
         end
      end
   end

   // Monitor: every strobe or completed transfer is one event, compared against the scoreboard
   initial begin
      int         cnt;
      ev_t        e;
      logic [6:0] s;
      bit         x, ok;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) cnt = 0;
         else begin
            cnt++;
            s = {ir_load, mdr_load, pc_inc, alu_latch, reg_we_h, reg_we_l, pc_load};
            x = mem_req && mem_ack;
            if (s != 7'd0 || x) begin
               checks++;
               if (expQ.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_event: got strb=%b xfer=%b addr=%h, expected no event", s, x, mem_addr);
               end else begin
                  e = expQ.pop_front();
                  ok = (s == e.strb) && (x == e.xfer) && (e.gap < 0 || cnt == e.gap);
                  if (e.xfer) ok = ok && mem_we == e.we && mem_byte == e.byt && mem_addr == e.addr
                                  && (!e.we || mem_wdata == e.wdata);
                  if (e.strb[3]) ok = ok && (ctrl_out == e.ctrl);
                  if (!ok) begin
                     errors++;
                     $display("FAIL event: got strb=%b xfer=%b we=%b byte=%b addr=%h wdata=%h gap=%0d ctrl=%h; expected strb=%b xfer=%b we=%b byte=%b addr=%h wdata=%h gap=%0d ctrl=%h",
                              s, x, mem_we, mem_byte, mem_addr, mem_wdata, cnt, ctrl_out,
                              e.strb, e.xfer, e.we, e.byt, e.addr, e.wdata, e.gap, e.ctrl);
                  end
               end
               cnt = 0;
            end
         end
      end
   end

   task automatic finishBatch(input string name);
      int k;
      k = 0;
      while (k < 3000) begin
         @(posedge clk);
         #2;
         if (instrQ.size() == 0) run = 1'b0;
         if (instrQ.size() == 0 && !busy) break;
         k++;
      end
      checks++;
      if (k >= 3000) begin
         errors++;
         $display("FAIL %s_timeout: busy=%b pending=%0d, expected idle", name, busy, instrQ.size());
      end
      check({name, "_drained"}, 64'(expQ.size()), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int   k, reqs;
      logic [32:0] c;
      reset_n = 1'b0;
      run = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req", 64'(mem_req), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_trap", 64'(trap), 64'd0);
      check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
      check("rst_strobes", 64'({ir_load, mdr_load, pc_inc, alu_latch, reg_we_h, reg_we_l, pc_load, mem_we}), 64'd0);

      // Directed batch: ALU op, byte load with waits, conditional PC writes, word store ending the run
      firstEv = 1'b1; sinceLast = 0;
      c = mkCtrl(1'b0, 1'b1, 1'b1, 4'b0000, 6'b000000);
      c[17:15] = 3'd3;
      issue(mkInstr(c, 1'b0, 1'b0, 16'h0000, 16'h1111, 0, 0));
      issue(mkInstr(mkCtrl(1'b0, 1'b0, 1'b1, 4'b1000, 6'b000000), 1'b0, 1'b0, 16'h1234, 16'h2222, 0, 2));
      issue(mkInstr(mkCtrl(1'b1, 1'b1, 1'b1, 4'b0000, 6'b110110), 1'b1, 1'b0, 16'h0000, 16'h0040, 0, 0));
      issue(mkInstr(mkCtrl(1'b1, 1'b1, 1'b1, 4'b0000, 6'b110110), 1'b0, 1'b1, 16'h0000, 16'h0077, 1, 0));
      issue(mkInstr(mkCtrl(1'b0, 1'b0, 1'b0, 4'b0001, 6'b000000), 1'b0, 1'b0, 16'h5678, 16'hBEEF, 0, 0));
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      check("first_fetch_req", 64'(mem_req), 64'd1);
      check("first_fetch_addr", 64'(mem_addr), 64'h0010);
      check("first_fetch_busy", 64'(busy), 64'd1);
      finishBatch("directed");
      check("ctrl_out_held", 64'(ctrl_out), 64'(lastCtrl));
      check("idle_req", 64'(mem_req), 64'd0);

      for (int b = 0; b < 3; b++) begin
         firstEv = 1'b1; sinceLast = 0;
         for (int i = 0; i < 10; i++) issue(randInstr());
         run = 1'b1;
         finishBatch("random");
      end

      // Illegal word traps and the sequencer goes silent until reset
      firstEv = 1'b1; sinceLast = 0;
      issue(randInstr());
      issue(mkInstr(mkCtrl(1'b0, 1'b1, 1'b1, 4'b0110, 6'b000000), 1'b0, 1'b0, 16'h0, 16'h0, 1, 0));
      run = 1'b1;
      k = 0;
      while (k < 3000) begin
         @(posedge clk);
         #2;
         if (instrQ.size() == 0) run = 1'b0;
         if (trap) break;
         k++;
      end
      check("trap_set", 64'(trap), 64'd1);
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req) reqs++;
      end
      check("trap_no_req", 64'(reqs), 64'd0);
      check("trap_sticky", 64'(trap), 64'd1);
      check("trap_busy", 64'(busy), 64'd1);
      check("trap_drained", 64'(expQ.size()), 64'd0);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("trap_cleared", 64'(trap), 64'd0);
      check("trap_reset_busy", 64'(busy), 64'd0);
      @(negedge clk);
      #2 reset_n = 1'b1;

      // Reset during a fetch wait state drops the request without waiting for a clock
      instrQ.push_back(mkInstr(mkCtrl(1'b0, 1'b1, 1'b1, 4'b0000, 6'b000000), 1'b0, 1'b0, 16'h0, 16'h0, 6, 0));
      run = 1'b1;
      k = 0;
      while (k < 50) begin
         @(negedge clk);
         if (mem_req) break;
         k++;
      end
      check("abort_req_seen", 64'(mem_req), 64'd1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      run = 1'b0;
      #1;
      check("abort_req_drop", 64'(mem_req), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      instrQ.delete();
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_stays_idle", 64'({busy, mem_req}), 64'd0);
      check("final_drained", 64'(expQ.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
